// File: rtl/key_fifo_reader.sv
// rtl/key_fifo_reader.sv - read-side burst master for the 128-bit FWFT KeyHash FIFO
module key_fifo_reader #(
  parameter int DATA_W  = 128,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              rd_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              key_valid,
  output logic [DATA_W-1:0] key_data,
  input  logic              key_ready,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  key_cnt
);

  localparam int STV_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   remaining_q;
  logic [STV_W-1:0]   starve_q;
  logic [CNT_W-1:0]   key_cnt_q;
  logic               timeout_q;

  logic [1:0]         occ_q;
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [DATA_W-1:0]  buf_q [0:1];

  logic               accept;

  // Pop only from registered state and the empty flag so the FIFO never sees key_ready.
  assign fifo_rd_en  = (state_q == READ) && !fifo_empty && (remaining_q != '0) && (occ_q < 2'd2);
  assign accept      = key_valid && key_ready;

  assign key_valid   = (occ_q != 2'd0);
  assign key_data    = buf_q[rd_ptr_q];
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign timeout_err = timeout_q;
  assign key_cnt     = key_cnt_q;

  // Output buffer bookkeeping: pointers and occupancy of the 2-entry in-order queue.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      occ_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (fifo_rd_en) wr_ptr_q <= ~wr_ptr_q;
      if (accept)     rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, fifo_rd_en} - {1'b0, accept};
    end
  end

  // Output buffer storage: capture the FIFO head word on each pop.
  always_ff @(posedge rd_clk) begin
    if (fifo_rd_en) buf_q[wr_ptr_q] <= fifo_dout;
  end

  // Burst control FSM with remaining-key, starvation and delivered-key counters.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      starve_q    <= '0;
      key_cnt_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      if (accept && (key_cnt_q != {CNT_W{1'b1}})) key_cnt_q <= key_cnt_q + 1'b1;

      case (state_q)
        IDLE: begin
          starve_q <= '0;
          if (start) begin
            key_cnt_q <= '0;
            timeout_q <= 1'b0;
            if (burst_len != '0) begin
              remaining_q <= burst_len;
              state_q     <= READ;
            end else begin
              state_q <= DONE;
            end
          end
        end
        READ: begin
          if (fifo_rd_en) remaining_q <= remaining_q - 1'b1;
          if (remaining_q == '0) begin
            starve_q <= '0;
            state_q  <= DRAIN;
          end else if (fifo_empty) begin
            if (starve_q == STV_W'(TIMEOUT - 1)) begin
              starve_q  <= '0;
              timeout_q <= 1'b1;
              state_q   <= DRAIN;
            end else begin
              starve_q <= starve_q + 1'b1;
            end
          end else begin
            starve_q <= '0;
          end
        end
        DRAIN: begin
          if (occ_q == 2'd0) state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_fifo_reader.sv
// tb/tb_key_fifo_reader.sv - scoreboard bench for key_fifo_reader
module tb_key_fifo_reader;
  localparam int DW = 128;
  localparam int CW = 8;
  localparam int TO = 16;

  logic          rd_clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] burst_len;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic          key_valid;
  logic [DW-1:0] key_data;
  logic          key_ready;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic [CW-1:0] key_cnt;

  key_fifo_reader #(.DATA_W(DW), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .rd_clk(rd_clk), .rst(rst), .start(start), .burst_len(burst_len),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready),
    .busy(busy), .done(done), .timeout_err(timeout_err), .key_cnt(key_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic          force_empty;
  int total = 0;
  int bad   = 0;
  int cyc, rd_count, rd_run, rd_run_max, v_count, acc_count, done_count;
  int first_rd, first_v, to_cyc, done_cyc;
  logic          hold_pending, last_done, finished;
  logic [DW-1:0] hold_data;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = force_empty || (fifo_q.size() == 0);
    fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic load(input int n, input int base);
    logic [DW-1:0] k;
    for (int i = 0; i < n; i++) begin
      k = {32'(base + i), $urandom(), $urandom(), $urandom()};
      fifo_q.push_back(k);
      exp_q.push_back(k);
    end
    refresh();
  endtask

  task automatic tick();
    logic rd, v, r;
    logic [DW-1:0] d, e;
    @(negedge rd_clk);
    rd = fifo_rd_en; v = key_valid; r = key_ready; d = key_data;
    if (rd) begin
      chk("rd_while_empty", {127'd0, fifo_empty}, '0);
      rd_count++; rd_run++;
      if (rd_run > rd_run_max) rd_run_max = rd_run;
      if (first_rd < 0) first_rd = cyc;
    end else begin
      rd_run = 0;
    end
    if (v) begin
      v_count++;
      if (first_v < 0) first_v = cyc;
    end
    if (hold_pending) chk("key_hold", d, hold_data);
    hold_pending = v && !r;
    hold_data    = d;
    if (v && r) begin
      acc_count++;
      if (exp_q.size() == 0) chk("extra_key", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("key_data", d, e);
      end
    end
    if (done) begin
      done_count++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (timeout_err && to_cyc < 0) to_cyc = cyc;
    last_done = done;
    @(posedge rd_clk);
    #1;
    if (rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
    cyc++;
    refresh();
  endtask

  task automatic clear_stats();
    cyc = 0; rd_count = 0; rd_run = 0; rd_run_max = 0; v_count = 0; acc_count = 0;
    done_count = 0; first_rd = -1; first_v = -1; to_cyc = -1; done_cyc = -1;
    hold_pending = 1'b0; last_done = 1'b0; finished = 1'b0;
  endtask

  task automatic run(input int len, input int stall_after, input int stall_len,
                     input int gap_at, input int gap_len);
    int stalled;
    stalled = 0;
    clear_stats();
    start = 1'b1; burst_len = CW'(len);
    tick();
    start = 1'b0;
    clear_stats();
    for (int c = 0; c < 300; c++) begin
      force_empty = (c >= gap_at) && (c < gap_at + gap_len);
      refresh();
      if (acc_count >= stall_after && stalled < stall_len) begin
        key_ready = 1'b0; stalled++;
      end else begin
        key_ready = 1'b1;
      end
      tick();
      if (last_done) begin
        finished = 1'b1;
        break;
      end
    end
    force_empty = 1'b0; key_ready = 1'b1; refresh();
    chk("burst_budget", {127'd0, finished}, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; burst_len = '0; key_ready = 1'b1; force_empty = 1'b0;
    refresh();
    clear_stats();

    // reset
    @(posedge rd_clk); @(posedge rd_clk); #1;
    chk("rst_rd_en", {127'd0, fifo_rd_en}, 0);
    chk("rst_valid", {127'd0, key_valid}, 0);
    chk("rst_busy", {127'd0, busy}, 0);
    chk("rst_done", {127'd0, done}, 0);
    chk("rst_timeout", {127'd0, timeout_err}, 0);
    chk("rst_key_cnt", DW'(key_cnt), 0);
    rst = 1'b0;
    @(posedge rd_clk); #1;

    // 10 keys, full throughput
    load(10, 100);
    run(10, 1000, 0, 1000, 0);
    chk("t2_pops", rd_count, 10);
    chk("t2_pop_run", rd_run_max, 10);
    chk("t2_valid_cycles", v_count, 10);
    chk("t2_latency", first_v - first_rd, 1);
    chk("t2_done_pulses", done_count, 1);
    chk("t2_key_cnt", DW'(key_cnt), 10);
    chk("t2_all_delivered", exp_q.size(), 0);
    chk("t2_idle_after", {127'd0, busy}, 0);

    // backpressure: ready low 5 cycles after key 3
    load(10, 200);
    run(10, 3, 5, 1000, 0);
    chk("t3_pops", rd_count, 10);
    chk("t3_pop_dropped", {127'd0, rd_run_max < 10}, 1);
    chk("t3_done_pulses", done_count, 1);
    chk("t3_key_cnt", DW'(key_cnt), 10);
    chk("t3_all_delivered", exp_q.size(), 0);

    // 3-cycle empty gap mid-burst
    load(10, 300);
    run(10, 1000, 0, 4, 3);
    chk("t4_pops", rd_count, 10);
    chk("t4_no_timeout", {127'd0, timeout_err}, 0);
    chk("t4_key_cnt", DW'(key_cnt), 10);
    chk("t4_all_delivered", exp_q.size(), 0);

    // starvation timeout: 4 keys for an 8-key burst
    load(4, 400);
    run(8, 1000, 0, 1000, 0);
    chk("t5_pops", rd_count, 4);
    chk("t5_timeout_err", {127'd0, timeout_err}, 1);
    chk("t5_timeout_cycle", to_cyc, 4 + TO);
    chk("t5_done_cycle", done_cyc, 5 + TO);
    chk("t5_done_pulses", done_count, 1);
    chk("t5_key_cnt", DW'(key_cnt), 4);
    chk("t5_all_delivered", exp_q.size(), 0);

    // zero-length burst; also clears timeout_err
    run(0, 1000, 0, 1000, 0);
    chk("t6_zero_pops", rd_count, 0);
    chk("t6_zero_done_cycle", done_cyc, 0);
    chk("t6_timeout_cleared", {127'd0, timeout_err}, 0);
    chk("t6_zero_key_cnt", DW'(key_cnt), 0);

    // reset mid-burst
    load(10, 500);
    clear_stats();
    start = 1'b1; burst_len = CW'(10);
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_midburst_busy", {127'd0, busy}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_rd_en", {127'd0, fifo_rd_en}, 0);
    chk("t6_rst_valid", {127'd0, key_valid}, 0);
    chk("t6_rst_busy", {127'd0, busy}, 0);
    chk("t6_rst_done", {127'd0, done}, 0);
    chk("t6_rst_timeout", {127'd0, timeout_err}, 0);
    chk("t6_rst_key_cnt", DW'(key_cnt), 0);
    fifo_q.delete();
    exp_q.delete();
    refresh();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
